conversor_fpu_int: RTL and testbench

CONVERSOR_FPU_INT -- requirements
Module: conversor_fpu_int

---
 rtl/conversor_fpu_int_pkg.sv | 36 +++
 rtl/conversor_fpu_int.sv | 128 ++++++++++++
 tb/tb_conversor_fpu_int.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/conversor_fpu_int_pkg.sv
// Shared definitions for the custom-float to integer converter: field layout,
// exponent landmarks, status encoding and FSM states.
package conversor_fpu_int_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 10;
  localparam int MANT_W = 21;
  localparam int DATA_W = SIGN_W + EXP_W + MANT_W;
  localparam int BIAS   = 511;
  localparam int CNT_W  = 5;

  localparam logic [EXP_W-1:0] EXP_ZERO = '0;
  localparam logic [EXP_W-1:0] EXP_MAX  = '1;
  localparam logic [EXP_W-1:0] EXP_BIAS = EXP_W'(BIAS);
  // E = 21: the 22-bit significand is already an integer, no shift needed
  localparam logic [EXP_W-1:0] EXP_UNIT = EXP_W'(BIAS + MANT_W);
  // E = 31: only -2^31 is representable at this exponent
  localparam logic [EXP_W-1:0] EXP_TOP  = EXP_W'(BIAS + DATA_W - 1);

  typedef enum logic [3:0] {
    STATUS_ESPERA    = 4'b0000,
    STATUS_EXACT     = 4'b0001,
    STATUS_OVERFLOW  = 4'b0010,
    STATUS_UNDERFLOW = 4'b0100,
    STATUS_INEXACT   = 4'b1000
  } status_e;

  typedef enum logic [2:0] {
    ESPERA,
    EXTRAI,
    DESLOCA,
    SINAL,
    SAIDA
  } fsm_e;

endpackage

// File: rtl/conversor_fpu_int.sv
// Converts a 32-bit custom float (bias 511, 21-bit mantissa) to a signed 32-bit
// integer, truncating toward zero with a serial one-bit-per-cycle shifter.
module conversor_fpu_int
  import conversor_fpu_int_pkg::*;
(
  input  logic              clock_100KHz,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] op_in,
  output logic [DATA_W-1:0] data_out,
  output logic [3:0]        status_out,
  output logic              busy,
  output logic              done,
  output fsm_e              state_dbg_o
);

  // Handshake: start is a request sampled only in ESPERA; done is a one-cycle
  // pulse and data_out/status_out are valid from that cycle until the next done.

  fsm_e              state_q, state_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic [DATA_W-1:0] mag_q, mag_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sticky_q, sticky_d;
  logic              left_q, left_d;
  logic [DATA_W-1:0] data_q, data_d;
  status_e           status_q, status_d;

  logic              op_sign;
  logic [EXP_W-1:0]  op_exp;
  logic [MANT_W-1:0] op_mant;

  assign op_sign = op_q[DATA_W-1];
  assign op_exp  = op_q[DATA_W-2 -: EXP_W];
  assign op_mant = op_q[MANT_W-1:0];

  always_ff @(posedge clock_100KHz) begin
    if (reset) begin
      state_q  <= ESPERA;
      op_q     <= '0;
      mag_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      left_q   <= 1'b0;
      data_q   <= '0;
      status_q <= STATUS_ESPERA;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mag_q    <= mag_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      left_q   <= left_d;
      data_q   <= data_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mag_d    = mag_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    left_d   = left_q;
    data_d   = data_q;
    status_d = status_q;
    case (state_q)
      ESPERA: begin
        if (start) begin
          op_d    = op_in;
          state_d = EXTRAI;
        end
      end
      EXTRAI: begin
        mag_d    = {{(DATA_W-MANT_W-1){1'b0}}, 1'b1, op_mant};
        sticky_d = 1'b0;
        if (op_exp == EXP_ZERO) begin
          data_d   = '0;
          status_d = (op_mant == '0) ? STATUS_EXACT : STATUS_UNDERFLOW;
          state_d  = SAIDA;
        end else if (op_exp == EXP_MAX || op_exp > EXP_TOP ||
                     (op_exp == EXP_TOP && !(op_sign && op_mant == '0))) begin
          data_d   = op_sign ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
          status_d = STATUS_OVERFLOW;
          state_d  = SAIDA;
        end else if (op_exp < EXP_BIAS) begin
          data_d   = '0;
          status_d = STATUS_UNDERFLOW;
          state_d  = SAIDA;
        end else begin
          left_d  = (op_exp > EXP_UNIT);
          cnt_d   = left_d ? CNT_W'(op_exp - EXP_UNIT) : CNT_W'(EXP_UNIT - op_exp);
          state_d = (cnt_d != '0) ? DESLOCA : SINAL;
        end
      end
      DESLOCA: begin
        if (left_q) begin
          mag_d = mag_q << 1;
        end else begin
          mag_d    = mag_q >> 1;
          sticky_d = sticky_q | mag_q[0];
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = SINAL;
      end
      SINAL: begin
        // A zero magnitude negates to zero, so -0 never escapes
        data_d   = op_sign ? (~mag_q + 1'b1) : mag_q;
        status_d = sticky_q ? STATUS_INEXACT : STATUS_EXACT;
        state_d  = SAIDA;
      end
      SAIDA: begin
        state_d = ESPERA;
      end
      default: begin
        state_d = ESPERA;
      end
    endcase
  end

  assign data_out    = data_q;
  assign status_out  = status_q;
  assign busy        = (state_q != ESPERA);
  assign done        = (state_q == SAIDA);
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_conversor_fpu_int.sv
// Directed bench for conversor_fpu_int: expected results are queued when a
// conversion is requested and popped when done is observed.
module tb_conversor_fpu_int;
  import conversor_fpu_int_pkg::*;

  logic        clock_100KHz = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] op_in;
  logic [31:0] data_out;
  logic [3:0]  status_out;
  logic        busy;
  logic        done;
  fsm_e        state_dbg;

  int checks        = 0;
  int errors        = 0;
  int done_seen     = 0;
  int done_expected = 0;

  logic [43:0] exp_q[$];

  localparam logic [3:0] S_EXACT = 4'b0001;
  localparam logic [3:0] S_OVF   = 4'b0010;
  localparam logic [3:0] S_UNF   = 4'b0100;
  localparam logic [3:0] S_INEX  = 4'b1000;

  conversor_fpu_int dut (
    .clock_100KHz (clock_100KHz),
    .reset        (reset),
    .start        (start),
    .op_in        (op_in),
    .data_out     (data_out),
    .status_out   (status_out),
    .busy         (busy),
    .done         (done),
    .state_dbg_o  (state_dbg)
  );

  // clock / reset
  always #5000 clock_100KHz = ~clock_100KHz;

  always @(negedge clock_100KHz) if (done === 1'b1) done_seen++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // driver: one conversion, expectation queued at request, checked at done
  task automatic convert(input logic [31:0] op, input logic [31:0] ed,
                         input logic [3:0] es, input logic [7:0] elat);
    logic [43:0] e;
    int cyc;
    exp_q.push_back({elat, es, ed});
    @(negedge clock_100KHz);
    start = 1'b1;
    op_in = op;
    @(negedge clock_100KHz);
    start = 1'b0;
    op_in = $urandom;
    cyc = 0;
    check("busy_after_start", 64'(busy), 64'(1));
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clock_100KHz);
      cyc++;
    end
    done_expected++;
    e = exp_q.pop_front();
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL timeout op=%h: no done after %0d cycles, expected done", op, cyc);
    end else begin
      check("data_out", 64'(data_out), 64'(e[31:0]));
      check("status_out", 64'(status_out), 64'(e[35:32]));
      check("latency", 64'(cyc), 64'(e[43:36]));
    end
    @(negedge clock_100KHz);
    check("done_single", 64'(done), 64'(0));
    check("busy_idle", 64'(busy), 64'(0));
    check("data_hold", 64'(data_out), 64'(e[31:0]));
    check("status_hold", 64'(status_out), 64'(e[35:32]));
  endtask

  initial begin
    int base;
    reset = 1'b1;
    start = 1'b0;
    op_in = '0;
    repeat (3) @(negedge clock_100KHz);
    check("rst_data", 64'(data_out), 64'(0));
    check("rst_status", 64'(status_out), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    reset = 1'b0;
    @(negedge clock_100KHz);

    convert(32'h3FE00000, 32'h00000001, S_EXACT, 8'd23);
    convert(32'h42800000, 32'h00200000, S_EXACT, 8'd2);
    convert(32'hBFF00000, 32'hFFFFFFFF, S_INEX,  8'd23);
    convert(32'hC3C00000, 32'h80000000, S_EXACT, 8'd12);
    convert(32'h43E00000, 32'h7FFFFFFF, S_OVF,   8'd1);
    convert(32'h3F000000, 32'h00000000, S_UNF,   8'd1);
    convert(32'h00000000, 32'h00000000, S_EXACT, 8'd1);
    convert(32'h00000001, 32'h00000000, S_UNF,   8'd1);
    convert(32'hFFE00000, 32'h80000000, S_OVF,   8'd1);
    convert(32'h43C00001, 32'h7FFFFFFF, S_OVF,   8'd1);
    convert(32'hC3C00001, 32'h80000000, S_OVF,   8'd1);
    convert(32'h40080000, 32'h00000002, S_INEX,  8'd22);
    convert(32'h40100000, 32'h00000003, S_EXACT, 8'd22);
    convert(32'h43100000, 32'h03000000, S_EXACT, 8'd6);
    convert(32'hC3100000, 32'hFD000000, S_EXACT, 8'd6);

    // reset in the middle of the shift phase
    @(negedge clock_100KHz);
    start = 1'b1;
    op_in = 32'h3FE00000;
    @(negedge clock_100KHz);
    start = 1'b0;
    repeat (5) @(negedge clock_100KHz);
    check("mid_state_desloca", 64'(state_dbg), 64'(DESLOCA));
    reset = 1'b1;
    @(negedge clock_100KHz);
    check("abort_data", 64'(data_out), 64'(0));
    check("abort_status", 64'(status_out), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    reset = 1'b0;
    base = done_seen;
    repeat (30) @(negedge clock_100KHz);
    check("no_done_after_abort", 64'(done_seen), 64'(base));
    convert(32'h3FE00000, 32'h00000001, S_EXACT, 8'd23);

    // start held high: back-to-back conversions every 4 cycles
    @(negedge clock_100KHz);
    start = 1'b1;
    op_in = 32'h42800000;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock_100KHz);
      check("held_done", 64'(done), 64'((c % 4) == 2));
      check("held_busy", 64'(busy), 64'((c % 4) != 3));
      if ((c % 4) == 2) begin
        check("held_data", 64'(data_out), 64'(32'h00200000));
        check("held_status", 64'(status_out), 64'(S_EXACT));
      end
    end
    start = 1'b0;
    done_expected += 3;
    repeat (6) @(negedge clock_100KHz);
    check("done_total", 64'(done_seen), 64'(done_expected));
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
